lif_neuron_array: RTL and testbench

Synthesizable, fixed-point array of N_CH leaky integrate-and-fire neurons with per-channel refractory period and optional adaptive threshold. Input currents arrive as channel-addressed valid/ready transactions. A global `tick` advances simulated time through a small FSM that applies leak, tests thresholds and emits a registered spike vector. The block sits between the synapse/current-accumulation stage and the spike router, and is the hardware successor to the real-valued behavioural neuron model.

---
 rtl/lif_neuron_array.sv | 199 +++++++++++++++++++
 tb/tb_lif_neuron_array.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_array.sv
// lif_neuron_array: N_CH leaky integrate-and-fire neurons, tick-driven.
// Define LIF_ADAPT_EN to build per-channel adaptive thresholds.
module lif_neuron_array #(
  parameter int N_CH        = 4,
  parameter int W           = 16,
  parameter int VTH0        = 100,
  parameter int VRESET      = 0,
  parameter int LEAK_SHIFT  = 4,
  parameter int REFRAC_CYC  = 2,
  parameter int ADAPT_INC   = 20,
  parameter int ADAPT_SHIFT = 3,
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CHW-1:0]      in_ch,
  input  logic signed [W-1:0] in_cur,
  output logic [N_CH-1:0]     spike,
  output logic                spike_valid,
  output logic                tick_overrun
);

  localparam int RW = (REFRAC_CYC < 1) ? 1 : $clog2(REFRAC_CYC + 1);

  localparam logic signed [W-1:0] L_VTH0 = W'(VTH0);
  localparam logic signed [W-1:0] L_VRST = W'(VRESET);
  localparam logic [RW-1:0]       L_REF  = RW'(REFRAC_CYC);

  typedef enum logic [1:0] {
    S_INTEG,
    S_LEAK,
    S_FIRE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic signed [W-1:0] r_v   [N_CH];
  logic [RW-1:0]       r_ref [N_CH];
  logic signed [W-1:0] w_vth [N_CH];
  logic [N_CH-1:0]     w_fire;
  logic [N_CH-1:0]     r_spike;
  logic                r_spike_valid;
  logic                r_overrun;
  logic                w_hs;
  logic                w_ch_ok;

  // Clamp a W+1 bit result back into W bits instead of wrapping.
  function automatic logic signed [W-1:0] f_sat(
    input logic signed [W:0] x
  );
    if (x[W] == x[W-1])
      f_sat = x[W-1:0];
    else if (x[W])
      f_sat = {1'b1, {(W-1){1'b0}}};
    else
      f_sat = {1'b0, {(W-1){1'b1}}};
  endfunction

  function automatic logic signed [W-1:0] f_add(
    input logic signed [W-1:0] a,
    input logic signed [W-1:0] b
  );
    f_add = f_sat({a[W-1], a} + {b[W-1], b});
  endfunction

  function automatic logic signed [W-1:0] f_sub(
    input logic signed [W-1:0] a,
    input logic signed [W-1:0] b
  );
    f_sub = f_sat({a[W-1], a} - {b[W-1], b});
  endfunction

  assign in_ready     = (r_state == S_INTEG) && !rst;
  assign w_hs         = in_valid && in_ready;
  assign w_ch_ok      = 32'(in_ch) < 32'(N_CH);
  assign spike        = r_spike;
  assign spike_valid  = r_spike_valid;
  assign tick_overrun = r_overrun;

  // Threshold test: refractory channels never fire.
  always_comb begin
    w_fire = '0;
    for (int i = 0; i < N_CH; i++)
      w_fire[i] = (r_ref[i] == '0) && (r_v[i] >= w_vth[i]);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_INTEG;
    else     r_state <= w_next;
  end

  // Next-state: one tick walks INTEG -> LEAK -> FIRE -> INTEG.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INTEG: if (tick) w_next = S_LEAK;
      S_LEAK:  w_next = S_FIRE;
      S_FIRE:  w_next = S_INTEG;
      default: w_next = S_INTEG;
    endcase
  end

  // Membrane and refractory update, one phase per state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_v[i]   <= '0;
        r_ref[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        case (r_state)
          S_INTEG: begin
            if (w_hs && w_ch_ok && (32'(in_ch) == 32'(i))
                && (r_ref[i] == '0))
              r_v[i] <= f_add(r_v[i], in_cur);
          end
          S_LEAK: begin
            if (r_ref[i] == '0)
              r_v[i] <= f_sub(r_v[i], r_v[i] >>> LEAK_SHIFT);
          end
          S_FIRE: begin
            if (r_ref[i] != '0) begin
              r_ref[i] <= r_ref[i] - RW'(1);
              r_v[i]   <= L_VRST;
            end else if (w_fire[i]) begin
              r_ref[i] <= L_REF;
              r_v[i]   <= L_VRST;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Spike vector is registered at the end of the fire phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_spike       <= '0;
      r_spike_valid <= 1'b0;
    end else begin
      r_spike_valid <= 1'b0;
      if (r_state == S_FIRE) begin
        r_spike       <= w_fire;
        r_spike_valid <= 1'b1;
      end
    end
  end

  // Sticky flag for ticks arriving mid-update.
  always_ff @(posedge clk) begin
    if (rst)
      r_overrun <= 1'b0;
    else if (tick && (r_state != S_INTEG))
      r_overrun <= 1'b1;
  end

`ifdef LIF_ADAPT_EN
  localparam logic signed [W-1:0] L_INC = W'(ADAPT_INC);

  logic signed [W-1:0] r_vth [N_CH];

  // Threshold rises on a spike and relaxes toward VTH0 otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++)
        r_vth[i] <= L_VTH0;
    end else if (r_state == S_FIRE) begin
      for (int i = 0; i < N_CH; i++) begin
        if (r_ref[i] == '0) begin
          if (w_fire[i])
            r_vth[i] <= f_add(r_vth[i], L_INC);
          else
            r_vth[i] <= f_sub(r_vth[i],
                          f_sub(r_vth[i], L_VTH0) >>> ADAPT_SHIFT);
        end
      end
    end
  end

  // Expose the adaptive thresholds to the fire test.
  always_comb begin
    for (int i = 0; i < N_CH; i++)
      w_vth[i] = r_vth[i];
  end
`else
  // Fixed threshold for every channel.
  always_comb begin
    for (int i = 0; i < N_CH; i++)
      w_vth[i] = L_VTH0;
  end
`endif

endmodule

// File: tb/tb_lif_neuron_array.sv
// tb_lif_neuron_array: directed vectors for lif_neuron_array.
// Build with LIF_ADAPT_EN to also cover the adaptive threshold.
module tb_lif_neuron_array;

  logic              clk = 1'b0;
  logic              rst;
  logic              tick;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_ch;
  logic signed [15:0] in_cur;
  logic [3:0]        spike;
  logic              spike_valid;
  logic              tick_overrun;

  logic              t5_tick;
  logic              t5_valid;
  logic              t5_ready;
  logic [2:0]        t5_ch;
  logic signed [15:0] t5_cur;
  logic [4:0]        t5_spike;
  logic              t5_sv;
  logic              t5_ovr;

  int n_vec = 0;
  int n_bad = 0;

  int v_snap [4];

  lif_neuron_array u_dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ch        (in_ch),
    .in_cur       (in_cur),
    .spike        (spike),
    .spike_valid  (spike_valid),
    .tick_overrun (tick_overrun)
  );

  lif_neuron_array #(.N_CH(5)) u_d5 (
    .clk          (clk),
    .rst          (rst),
    .tick         (t5_tick),
    .in_valid     (t5_valid),
    .in_ready     (t5_ready),
    .in_ch        (t5_ch),
    .in_cur       (t5_cur),
    .spike        (t5_spike),
    .spike_valid  (t5_sv),
    .tick_overrun (t5_ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [1:0] ch, input logic signed [15:0] cur);
    @(negedge clk);
    in_valid = 1'b1;
    in_ch    = ch;
    in_cur   = cur;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic tick_run(
    output logic [3:0] sp,
    output int         lat,
    output logic       rdy1,
    output logic       rdy2
  );
    lat  = 0;
    sp   = '0;
    rdy1 = 1'b1;
    rdy2 = 1'b1;
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) rdy1 = in_ready;
      if (k == 2) begin
        rdy2 = in_ready;
        v_snap[0] = u_dut.r_v[0];
        v_snap[1] = u_dut.r_v[1];
        v_snap[2] = u_dut.r_v[2];
        v_snap[3] = u_dut.r_v[3];
      end
      if (spike_valid) begin
        lat = k;
        sp  = spike;
        break;
      end
    end
  endtask

  initial begin
    logic [3:0] sp;
    int         lat;
    logic       r1, r2;
    int         pulses;

    rst = 1'b1; tick = 1'b0; in_valid = 1'b0; in_ch = '0; in_cur = '0;
    t5_tick = 1'b0; t5_valid = 1'b0; t5_ch = '0; t5_cur = '0;
    do_reset();

    @(negedge clk);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_spike", int'(spike), 0);
    chk("rst_sv", int'(spike_valid), 0);
    chk("rst_ovr", int'(tick_overrun), 0);
    chk("rst_v0", int'(u_dut.r_v[0]), 0);

    send(2'd0, 16'sd40);
    send(2'd0, 16'sd40);
    send(2'd0, 16'sd40);
    @(negedge clk);
    chk("fire_v0_int", int'(u_dut.r_v[0]), 120);
    tick_run(sp, lat, r1, r2);
    chk("fire_lat", lat, 3);
    chk("fire_rdy1", int'(r1), 0);
    chk("fire_rdy2", int'(r2), 0);
    chk("fire_leak", v_snap[0], 113);
    chk("fire_spike", int'(sp), 1);
    chk("fire_v0", int'(u_dut.r_v[0]), 0);
    @(negedge clk);
    chk("fire_sv_pulse", int'(spike_valid), 0);
    chk("fire_hold", int'(spike), 1);

    send(2'd0, 16'sd200);
    @(negedge clk);
    chk("ref1_drop", int'(u_dut.r_v[0]), 0);
    tick_run(sp, lat, r1, r2);
    chk("ref1_spike", int'(sp), 0);
    send(2'd0, 16'sd200);
    @(negedge clk);
    chk("ref2_drop", int'(u_dut.r_v[0]), 0);
    tick_run(sp, lat, r1, r2);
    chk("ref2_spike", int'(sp), 0);
    send(2'd0, 16'sd200);
    @(negedge clk);
    chk("ref3_acc", int'(u_dut.r_v[0]), 200);
    tick_run(sp, lat, r1, r2);
    chk("ref3_spike", int'(sp), 1);

    do_reset();
    send(2'd1, 16'sd64);
    tick_run(sp, lat, r1, r2);
    chk("leak1_v1", int'(u_dut.r_v[1]), 60);
    chk("leak1_spike", int'(sp), 0);
    tick_run(sp, lat, r1, r2);
    chk("leak2_v1", int'(u_dut.r_v[1]), 57);
    chk("leak2_spike", int'(sp), 0);

    do_reset();
    send(2'd2, 16'sh7FFF);
    send(2'd2, 16'sh7FFF);
    send(2'd3, 16'sh8000);
    send(2'd3, 16'sh8000);
    @(negedge clk);
    chk("sat_hi", int'(u_dut.r_v[2]), 32767);
    chk("sat_lo", int'(u_dut.r_v[3]), -32768);

    do_reset();
    send(2'd0, 16'sd50);
    @(negedge clk);
    tick     = 1'b1;
    in_valid = 1'b1;
    in_ch    = 2'd1;
    in_cur   = 16'sd150;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 tick = 1'b0;
    @(negedge clk);
    chk("ovr_set", int'(tick_overrun), 1);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      if (spike_valid) begin
        pulses++;
        chk("ovr_spike", int'(spike), 2);
      end
      @(negedge clk);
    end
    chk("ovr_pulses", pulses, 1);
    chk("ovr_sticky", int'(tick_overrun), 1);
    chk("conc_v0", int'(u_dut.r_v[0]), 47);

    @(negedge clk);
    t5_valid = 1'b1; t5_ch = 3'd5; t5_cur = 16'sd200;
    @(posedge clk);
    #1 t5_ch = 3'd4;
    @(posedge clk);
    #1 t5_valid = 1'b0;
    @(negedge clk);
    t5_tick = 1'b1;
    @(posedge clk);
    #1 t5_tick = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (t5_sv) begin
        lat = k;
        chk("oor_spike", int'(t5_spike), 16);
        break;
      end
    end
    chk("oor_lat", lat, 3);

    do_reset();
    @(negedge clk);
    chk("ovr_clear", int'(tick_overrun), 0);
    send(2'd0, 16'sd150);
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (spike_valid) pulses++;
    end
    chk("abort_pulses", pulses, 0);
    chk("abort_v0", int'(u_dut.r_v[0]), 0);
    chk("abort_ready", int'(in_ready), 1);

    do_reset();
    send(2'd0, 16'sd106);
    send(2'd1, 16'sd105);
    tick_run(sp, lat, r1, r2);
    chk("vth_leak0", v_snap[0], 100);
    chk("vth_leak1", v_snap[1], 99);
    chk("vth_spike", int'(sp), 1);
`ifdef LIF_ADAPT_EN
    chk("adapt_up", int'(u_dut.r_vth[0]), 120);
    tick_run(sp, lat, r1, r2);
    tick_run(sp, lat, r1, r2);
    chk("adapt_hold", int'(u_dut.r_vth[0]), 120);
    tick_run(sp, lat, r1, r2);
    chk("adapt_decay", int'(u_dut.r_vth[0]), 118);
    chk("adapt_base1", int'(u_dut.r_vth[1]), 100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
